// File: rtl/fpu_pkg.sv
// Shared types and constant helpers for the sequential FP unit.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SPECIAL,
    ST_ALIGN,
    ST_ITER,
    ST_NORM,
    ST_DONE
  } state_e;

  localparam int FLG_INV = 3;
  localparam int FLG_DZ  = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  localparam int unsigned FP_MAX_W = 64;

  // Constants are built at FP_MAX_W and truncated to the format width by the caller.
  function automatic logic [FP_MAX_W-1:0] fp_zero(input logic s, input int unsigned ew,
                                                  input int unsigned mw);
    return FP_MAX_W'(s) << (ew + mw);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic s, input int unsigned ew,
                                                 input int unsigned mw);
    logic [FP_MAX_W-1:0] e1;
    e1 = ((FP_MAX_W'(1) << ew) - FP_MAX_W'(1)) << mw;
    return e1 | fp_zero(s, ew, mw);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned ew, input int unsigned mw);
    return fp_inf(1'b0, ew, mw) | (FP_MAX_W'(1) << (mw - 1));
  endfunction

endpackage

// File: rtl/fpu_seq_if.sv
// Operand/result handshake bundle for fpu_seq.
interface fpu_seq_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fpu_norm.sv
// Leading-one normaliser: value = nm * 2^(ne-bias-(FW-2)); truncating, with range detect.
module fpu_norm
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned FW    = 48,
  parameter int unsigned EW    = 11
) (
  input  logic [FW-1:0]        nm,
  input  logic signed [EW-1:0] ne,
  output logic [MAN_W-1:0]     man,
  output logic [EXP_W-1:0]     expo,
  output logic                 zero,
  output logic                 ovf,
  output logic                 unf
);
  localparam int unsigned PW = $clog2(FW);
  localparam logic signed [EW-1:0] OFF  = EW'(FW - 2);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic [PW-1:0]        pos;
  logic [PW-1:0]        sh;
  logic [FW-1:0]        shifted;
  logic signed [EW-1:0] e;

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < FW; i++) begin
      if (nm[i]) pos = PW'(i);
    end
    sh      = PW'(FW - 1) - pos;
    shifted = nm << sh;
    e       = ne + $signed(EW'(pos)) - OFF;
    man     = MAN_W'(shifted >> (FW - 1 - MAN_W));
    expo    = e[EXP_W-1:0];
    zero    = ~|nm;
    ovf     = !zero && !e[EW-1] && (e >= EMAX);
    unf     = !zero && (e[EW-1] || (e == '0));
  end
endmodule

// File: rtl/fpu_seq.sv
// Multi-cycle FP add/sub/mul/div with handshakes; define FPU_DIV_EN to build the divider.
module fpu_seq
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic      clk,
  input logic      rst,
  fpu_seq_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned FW = 2 * MW;
  localparam int unsigned AW = MAN_W + 5;
  localparam int unsigned EW = EXP_W + 3;
  localparam int unsigned CW = $clog2(MAN_W + 3);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] SAT  = EW'(MAN_W + 3);
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

  state_e               state;
  op_e                  op_r;
  logic [W-1:0]         a_r, b_r, res_r;
  logic [3:0]           flg_r;
  logic                 in_ready_r, out_valid_r, sign_r;
  logic signed [EW-1:0] ea_r, eb_r, exp_r;
  logic [MW-1:0]        ma_r, mb_r;
  logic [FW-1:0]        acc_r;
  logic [CW-1:0]        cnt;
`ifdef FPU_DIV_EN
  logic [MW:0]          rem_r;
  logic                 rem_ge;
  logic [MW:0]          rem_nx;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = res_r;
  assign bus.flags     = flg_r;

  logic               sa, sb, sbe, eff_sub;
  logic [EXP_W-1:0]   xa, xb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [MW-1:0]      ma, mb;
  logic signed [EW-1:0] ea_s, eb_s;

  assign {sa, xa, fa} = a_r;
  assign {sb, xb, fb} = b_r;
  assign sbe     = sb ^ (op_r == OP_SUB);
  assign eff_sub = sa ^ sbe;
  assign a_zero  = (xa == '0);
  assign b_zero  = (xb == '0);
  assign a_nan   = (&xa) && (|fa);
  assign b_nan   = (&xb) && (|fb);
  assign a_inf   = (&xa) && !(|fa);
  assign b_inf   = (&xb) && !(|fb);
  assign ma      = a_zero ? '0 : {1'b1, fa};
  assign mb      = b_zero ? '0 : {1'b1, fb};
  assign ea_s    = $signed({3'b000, xa});
  assign eb_s    = $signed({3'b000, xb});

  logic         sp_hit;
  logic [W-1:0] sp_res;
  logic [3:0]   sp_flg;

  always_comb begin
    sp_hit = 1'b0;
    sp_res = '0;
    sp_flg = '0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
          sp_hit = 1'b1; sp_res = QNAN; sp_flg[FLG_INV] = 1'b1;
        end else if (a_inf) begin
          sp_hit = 1'b1; sp_res = W'(fp_inf(sa, EXP_W, MAN_W));
        end else if (b_inf) begin
          sp_hit = 1'b1; sp_res = W'(fp_inf(sbe, EXP_W, MAN_W));
        end
      end
      OP_MUL: begin
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
          sp_hit = 1'b1; sp_res = QNAN; sp_flg[FLG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
          sp_hit = 1'b1; sp_res = W'(fp_inf(sa ^ sb, EXP_W, MAN_W));
        end else if (a_zero || b_zero) begin
          sp_hit = 1'b1; sp_res = W'(fp_zero(sa ^ sb, EXP_W, MAN_W));
        end
      end
      default: begin
`ifdef FPU_DIV_EN
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          sp_hit = 1'b1; sp_res = QNAN; sp_flg[FLG_INV] = 1'b1;
        end else if (b_zero) begin
          sp_hit = 1'b1; sp_res = W'(fp_inf(sa ^ sb, EXP_W, MAN_W)); sp_flg[FLG_DZ] = 1'b1;
        end else if (a_inf) begin
          sp_hit = 1'b1; sp_res = W'(fp_inf(sa ^ sb, EXP_W, MAN_W));
        end else if (b_inf || a_zero) begin
          sp_hit = 1'b1; sp_res = W'(fp_zero(sa ^ sb, EXP_W, MAN_W));
        end
`else
        sp_hit = 1'b1; sp_res = QNAN; sp_flg[FLG_INV] = 1'b1;
`endif
      end
    endcase
  end

  // Alignment keeps 3 guard bits below the larger operand's LSB.
  logic                 a_big;
  logic signed [EW-1:0] ediff;
  logic [EW-1:0]        shamt;
  logic [MW+2:0]        small_sh;
  logic [AW-1:0]        big_ext, small_ext, addsum;
  logic [MW:0]          psum;

  always_comb begin
    a_big     = (ea_r > eb_r) || ((ea_r == eb_r) && (ma_r >= mb_r));
    ediff     = a_big ? (ea_r - eb_r) : (eb_r - ea_r);
    shamt     = (ediff > SAT) ? SAT : ediff;
    small_sh  = {(a_big ? mb_r : ma_r), 3'b000} >> shamt;
    big_ext   = {1'b0, ma_r, 3'b000};
    small_ext = {1'b0, acc_r[MW+2:0]};
    addsum    = eff_sub ? (big_ext - small_ext) : (big_ext + small_ext);
    psum      = {1'b0, acc_r[FW-1:MW]} + (mb_r[0] ? {1'b0, ma_r} : '0);
  end

`ifdef FPU_DIV_EN
  always_comb begin
    rem_ge = (rem_r >= {1'b0, mb_r});
    rem_nx = rem_ge ? (rem_r - {1'b0, mb_r}) : rem_r;
  end
`endif

  logic [MAN_W-1:0] n_man;
  logic [EXP_W-1:0] n_exp;
  logic             n_zero, n_ovf, n_unf;

  fpu_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FW(FW), .EW(EW)) u_norm (
    .nm(acc_r), .ne(exp_r), .man(n_man), .expo(n_exp),
    .zero(n_zero), .ovf(n_ovf), .unf(n_unf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_r        <= OP_ADD;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      flg_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sign_r      <= 1'b0;
      ea_r        <= '0;
      eb_r        <= '0;
      exp_r       <= '0;
      ma_r        <= '0;
      mb_r        <= '0;
      acc_r       <= '0;
      cnt         <= '0;
`ifdef FPU_DIV_EN
      rem_r       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            op_r       <= op_e'(bus.op);
            a_r        <= bus.a;
            b_r        <= bus.b;
            flg_r      <= '0;
            in_ready_r <= 1'b0;
            state      <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          ea_r   <= ea_s;
          eb_r   <= eb_s;
          ma_r   <= ma;
          mb_r   <= mb;
          acc_r  <= '0;
          cnt    <= '0;
          sign_r <= sa ^ sb;
          exp_r  <= (op_r == OP_MUL) ? (ea_s + eb_s - BIAS) : (ea_s - eb_s + BIAS);
`ifdef FPU_DIV_EN
          rem_r  <= {1'b0, ma};
`endif
          if (sp_hit) begin
            res_r <= sp_res;
            flg_r <= sp_flg;
            state <= ST_SPECIAL;
          end else if (op_r == OP_ADD || op_r == OP_SUB) begin
            state <= ST_ALIGN;
          end else begin
            state <= ST_ITER;
          end
        end
        ST_SPECIAL: begin
          out_valid_r <= 1'b1;
          state       <= ST_DONE;
        end
        ST_ALIGN: begin
          if (cnt == '0) begin
            ma_r   <= a_big ? ma_r : mb_r;
            exp_r  <= a_big ? ea_r : eb_r;
            sign_r <= a_big ? sa : sbe;
            acc_r  <= FW'(small_sh);
            cnt    <= CW'(1);
          end else begin
            acc_r <= FW'(addsum) << (FW - AW);
            state <= ST_NORM;
          end
        end
        ST_ITER: begin
          // The extra cycle at the terminal count lines the result up for NORM.
          if (op_r == OP_MUL) begin
            if (cnt == CW'(MW)) begin
              state <= ST_NORM;
            end else begin
              acc_r <= {psum, acc_r[MW-1:1]};
              mb_r  <= mb_r >> 1;
              cnt   <= cnt + CW'(1);
            end
          end
`ifdef FPU_DIV_EN
          else begin
            if (cnt == CW'(MAN_W + 2)) begin
              acc_r <= FW'(acc_r[MAN_W+1:0]) << (MAN_W - 1);
              state <= ST_NORM;
            end else begin
              acc_r <= {acc_r[FW-2:0], rem_ge};
              rem_r <= rem_nx << 1;
              cnt   <= cnt + CW'(1);
            end
          end
`endif
        end
        ST_NORM: begin
          if (n_zero) begin
            res_r <= '0;
          end else if (n_ovf) begin
            res_r          <= W'(fp_inf(sign_r, EXP_W, MAN_W));
            flg_r[FLG_OVF] <= 1'b1;
          end else if (n_unf) begin
            res_r          <= W'(fp_zero(sign_r, EXP_W, MAN_W));
            flg_r[FLG_UNF] <= 1'b1;
          end else begin
            res_r <= {sign_r, n_exp, n_man};
          end
          out_valid_r <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_seq.sv
// Directed self-checking bench for fpu_seq (default FP32 format).
module tb_fpu_seq;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  fpu_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fpu_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat_exp, input logic [31:0] res_exp,
                        input logic [3:0] flg_exp);
    int lat;
    @(negedge clk);
    check({tag, ":ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 2'd0;
    bus.a        = '1;
    bus.b        = '1;
    check({tag, ":busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ":lat"}, 32'(lat), 32'(lat_exp));
    check({tag, ":res"}, bus.result, res_exp);
    check({tag, ":flg"}, 32'(bus.flags), 32'(flg_exp));
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      check({tag, ":rdy_after"}, 32'(bus.in_ready), 32'd1);
      check({tag, ":vld_after"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 2'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst:in_ready", 32'(bus.in_ready), 32'd1);
    check("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("rst:result", bus.result, 32'h0);
    check("rst:flags", 32'(bus.flags), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_1_2", 2'd0, 32'h3F800000, 32'h40000000, 4, 32'h40400000, 4'b0000);
    run_op("add_3_m1", 2'd0, 32'h40400000, 32'hBF800000, 4, 32'h40000000, 4'b0000);
    run_op("sub_1_3", 2'd1, 32'h3F800000, 32'h40400000, 4, 32'hC0000000, 4'b0000);
    run_op("mul_15_2", 2'd2, 32'h3FC00000, 32'h40000000, 27, 32'h40400000, 4'b0000);
`ifdef FPU_DIV_EN
    run_op("div_6_3", 2'd3, 32'h40C00000, 32'h40400000, 28, 32'h40000000, 4'b0000);
    run_op("div_1_0", 2'd3, 32'h3F800000, 32'h00000000, 2, 32'h7F800000, 4'b0100);
`else
    run_op("div_6_3", 2'd3, 32'h40C00000, 32'h40400000, 2, 32'h7FC00000, 4'b1000);
    run_op("div_1_0", 2'd3, 32'h3F800000, 32'h00000000, 2, 32'h7FC00000, 4'b1000);
`endif
    run_op("mul_0_inf", 2'd2, 32'h00000000, 32'h7F800000, 2, 32'h7FC00000, 4'b1000);
    run_op("add_nan", 2'd0, 32'h7FC00001, 32'h3F800000, 2, 32'h7FC00000, 4'b1000);
    run_op("add_inf", 2'd0, 32'hFF800000, 32'h3F800000, 2, 32'hFF800000, 4'b0000);
    run_op("sub_cancel", 2'd1, 32'h3F800000, 32'h3F800000, 4, 32'h00000000, 4'b0000);
    run_op("mul_ovf", 2'd2, 32'h7F000000, 32'h7F000000, 27, 32'h7F800000, 4'b0010);
    run_op("mul_unf", 2'd2, 32'h00800000, 32'h80800000, 27, 32'h80000000, 4'b0001);

    bus.out_ready = 1'b0;
    run_op("bp_add", 2'd0, 32'h3F800000, 32'h40000000, 4, 32'h40400000, 4'b0000);
    repeat (10) @(posedge clk);
    #1;
    check("bp:result", bus.result, 32'h40400000);
    check("bp:flags", 32'(bus.flags), 32'h0);
    check("bp:out_valid", 32'(bus.out_valid), 32'd1);
    check("bp:in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp:rdy_after", 32'(bus.in_ready), 32'd1);
    check("bp:vld_after", 32'(bus.out_valid), 32'd0);

    @(negedge clk);
    bus.in_valid = 1'b1;
`ifdef FPU_DIV_EN
    bus.op = 2'd3;
    bus.a  = 32'h40C00000;
    bus.b  = 32'h40400000;
`else
    bus.op = 2'd2;
    bus.a  = 32'h3FC00000;
    bus.b  = 32'h40000000;
`endif
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid:in_ready_pre", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid:in_ready", 32'(bus.in_ready), 32'd1);
    check("mid:out_valid", 32'(bus.out_valid), 32'd0);
    check("mid:result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_add", 2'd0, 32'h3F800000, 32'h40000000, 4, 32'h40400000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
